// File: rtl/phys_reg_free_list.sv
// Physical register free list with a per-preg ready table.
// A circular buffer of spare pregs feeds rename; committed previous mappings are pushed back.
module phys_reg_free_list #(
    parameter int p_phys_addr_bits = 6,
    parameter int p_num_phys_regs  = 2 ** p_phys_addr_bits
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        alloc_val,
    input  logic                        alloc_rdy,
    output logic [p_phys_addr_bits-1:0] alloc_preg,
    input  logic                        complete_val,
    input  logic                        complete_wen,
    input  logic [p_phys_addr_bits-1:0] complete_preg,
    input  logic                        commit_val,
    input  logic                        commit_wen,
    input  logic [p_phys_addr_bits-1:0] commit_ppreg,
    input  logic [p_phys_addr_bits-1:0] query_preg [0:1],
    output logic                        query_ready [0:1],
    output logic [p_phys_addr_bits:0]   free_count,
    output logic                        overflow_err
);
    localparam int p_depth = p_num_phys_regs - 32;
    localparam int PTR_W   = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int CNT_W   = p_phys_addr_bits + 1;
    localparam int NREG    = 2 ** p_phys_addr_bits;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(p_depth - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(p_depth);

    logic [p_phys_addr_bits-1:0] fl_q [p_depth];
    logic [p_phys_addr_bits-1:0] fl_d [p_depth];
    logic [PTR_W-1:0]            head_q, head_d;
    logic [PTR_W-1:0]            tail_q, tail_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        ready_q [NREG];
    logic                        ready_d [NREG];
    logic                        overflow_q, overflow_d;

    logic alloc_fire;
    logic free_req;
    logic free_fire;
    logic complete_fire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign alloc_val    = (count_q != '0);
    assign alloc_preg   = fl_q[head_q];
    assign free_count   = count_q;
    assign overflow_err = overflow_q;

    always_comb begin
        alloc_fire    = alloc_val && alloc_rdy;
        free_req      = commit_val && commit_wen;
        // A push into a full list is accepted only if a pop frees a slot in the same cycle.
        free_fire     = free_req && ((count_q != FULL_CNT) || alloc_fire);
        complete_fire = complete_val && complete_wen;

        fl_d       = fl_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ready_d    = ready_q;
        overflow_d = overflow_q | (free_req && !free_fire);

        if (alloc_fire) begin
            head_d = ptr_inc(head_q);
        end
        if (free_fire) begin
            fl_d[tail_q] = commit_ppreg;
            tail_d       = ptr_inc(tail_q);
        end
        case ({alloc_fire, free_fire})
            2'b10:   count_d = count_q - 1'b1;
            2'b01:   count_d = count_q + 1'b1;
            default: count_d = count_q;
        endcase

        // Clear is applied after set so a same-preg allocation overrides a completion.
        if (complete_fire) begin
            ready_d[complete_preg] = 1'b1;
        end
        if (alloc_fire) begin
            ready_d[alloc_preg] = 1'b0;
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            query_ready[k] = ready_q[query_preg[k]]
                           | (complete_fire && (complete_preg == query_preg[k]))
                           | (query_preg[k] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= FULL_CNT;
            overflow_q <= 1'b0;
            for (int i = 0; i < p_depth; i++) begin
                fl_q[i] <= p_phys_addr_bits'(32 + i);
            end
            for (int i = 0; i < NREG; i++) begin
                ready_q[i] <= 1'b1;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            fl_q       <= fl_d;
            ready_q    <= ready_d;
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Randomised and directed bench for phys_reg_free_list; a queue-based reference model feeds a scoreboard.
module tb_phys_reg_free_list;
    localparam int W     = 6;
    localparam int DEPTH = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         alloc_val;
    logic         alloc_rdy;
    logic [W-1:0] alloc_preg;
    logic         complete_val;
    logic         complete_wen;
    logic [W-1:0] complete_preg;
    logic         commit_val;
    logic         commit_wen;
    logic [W-1:0] commit_ppreg;
    logic [W-1:0] query_preg [0:1];
    logic         query_ready [0:1];
    logic [W:0]   free_count;
    logic         overflow_err;

    phys_reg_free_list #(.p_phys_addr_bits(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_val    (alloc_val),
        .alloc_rdy    (alloc_rdy),
        .alloc_preg   (alloc_preg),
        .complete_val (complete_val),
        .complete_wen (complete_wen),
        .complete_preg(complete_preg),
        .commit_val   (commit_val),
        .commit_wen   (commit_wen),
        .commit_ppreg (commit_ppreg),
        .query_preg   (query_preg),
        .query_ready  (query_ready),
        .free_count   (free_count),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit    av;
        int    ap;
        int    fc;
        bit    ov;
        bit    q0;
        bit    q1;
        string tag;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: the free list is an ordered queue of preg numbers.
    int m_fl[$];
    bit m_rdy[64];
    bit m_ovf;

    function automatic void model_reset();
        m_fl.delete();
        for (int i = 0; i < DEPTH; i++) m_fl.push_back(32 + i);
        for (int i = 0; i < 64; i++) m_rdy[i] = 1'b1;
        m_ovf = 1'b0;
    endfunction

    function automatic bit model_query(int q, bit cv, bit cw, int cp);
        return (q == 0) || m_rdy[q] || (cv && cw && cp == q);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs mid-cycle against whatever the driver queued.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk({e.tag, ".alloc_val"}, int'(alloc_val), int'(e.av));
            if (e.av) chk({e.tag, ".alloc_preg"}, int'(alloc_preg), e.ap);
            chk({e.tag, ".free_count"}, int'(free_count), e.fc);
            chk({e.tag, ".overflow_err"}, int'(overflow_err), int'(e.ov));
            chk({e.tag, ".query_ready0"}, int'(query_ready[0]), int'(e.q0));
            chk({e.tag, ".query_ready1"}, int'(query_ready[1]), int'(e.q1));
        end
    end

    task automatic step(input bit r, input bit ar,
                        input bit cv, input bit cw, input int cp,
                        input bit mv, input bit mw, input int mp,
                        input int q0, input int q1, input string tag);
        exp_t e;
        bit   do_alloc;
        rst           = r;
        alloc_rdy     = ar;
        complete_val  = cv;
        complete_wen  = cw;
        complete_preg = W'(cp);
        commit_val    = mv;
        commit_wen    = mw;
        commit_ppreg  = W'(mp);
        query_preg[0] = W'(q0);
        query_preg[1] = W'(q1);

        e.av  = (m_fl.size() != 0);
        e.ap  = e.av ? m_fl[0] : 0;
        e.fc  = m_fl.size();
        e.ov  = m_ovf;
        e.q0  = model_query(q0, cv, cw, cp);
        e.q1  = model_query(q1, cv, cw, cp);
        e.tag = tag;
        sbq.push_back(e);

        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            do_alloc = e.av && ar;
            if (cv && cw) m_rdy[cp] = 1'b1;
            if (do_alloc) begin
                m_rdy[m_fl[0]] = 1'b0;
                void'(m_fl.pop_front());
            end
            if (mv && mw) begin
                if (m_fl.size() >= DEPTH) m_ovf = 1'b1;
                else m_fl.push_back(mp);
            end
        end
        #1;
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; alloc_rdy = 0; complete_val = 0; complete_wen = 0; complete_preg = '0;
        commit_val = 0; commit_wen = 0; commit_ppreg = '0;
        query_preg[0] = '0; query_preg[1] = '0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;

        // Drain the whole list in order, then see it empty.
        for (int i = 0; i < 32; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 32 + i, 0, "drain");
        idle("empty");
        idle("empty");

        // Free into an empty list: offered only from the next cycle.
        step(0, 1, 0, 0, 0, 1, 1, 5, 5, 0, "free_empty");
        step(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, "offer5");
        step(0, 0, 0, 0, 0, 1, 1, 10, 0, 0, "fill");
        step(0, 0, 0, 0, 0, 1, 1, 11, 0, 0, "fill");
        step(0, 0, 0, 0, 0, 1, 1, 12, 0, 0, "fill");
        step(0, 1, 0, 0, 0, 1, 1, 9, 0, 0, "alloc_free");
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 9, 12, "order");

        // Overflow on a full list is sticky and leaves contents alone.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
        step(0, 0, 0, 0, 0, 1, 1, 7, 0, 0, "ovf_push");
        idle("ovf_hold");
        for (int i = 0; i < 32; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 7, 40, "ovf_drain");
        idle("ovf_hold");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
        idle("ovf_clear");

        // Ready table: allocation clears, completion bypasses then sets.
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 40, 0, "adv");
        step(0, 1, 0, 0, 0, 0, 0, 0, 40, 0, "alloc40");
        step(0, 0, 0, 0, 0, 0, 0, 0, 40, 0, "q40_clear");
        step(0, 0, 1, 1, 40, 0, 0, 0, 40, 1, "q40_bypass");
        step(0, 0, 0, 0, 0, 0, 0, 0, 40, 41, "q40_table");
        step(0, 1, 1, 1, 41, 0, 0, 0, 41, 40, "clear_wins");
        step(0, 0, 0, 0, 0, 0, 0, 0, 41, 0, "q41_clear");
        step(0, 0, 1, 0, 42, 0, 0, 0, 42, 0, "no_wen");

        // Mid-operation reset wins over concurrent activity.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst");
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 32 + i, 0, "pre_rst");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 1, 33 + i, 0, 0, "pre_rst");
        step(1, 1, 1, 1, 50, 1, 1, 20, 33, 34, "rst_busy");
        step(0, 0, 0, 0, 0, 0, 0, 0, 33, 37, "post_rst");

        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            bit r;
            r = ($urandom_range(0, 199) == 0);
            step(r, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 63)), 1'($urandom),
                 1'($urandom_range(0, 3) != 0), int'($urandom_range(1, 63)),
                 int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), "rand");
        end
        idle("tail");

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/phys_reg_free_list.md
PHYS_REG_FREE_LIST -- requirements
Module: phys_reg_free_list

Parameters
REQ-001 SHALL have parameter p_phys_addr_bits, default 6; physical register specifier width; value SHALL be at least 6.
REQ-002 SHALL have parameter p_num_phys_regs, default 2**p_phys_addr_bits; total physical registers.
REQ-003 SHALL define localparam p_depth = p_num_phys_regs - 32; free-list capacity, not required to be a power of two.

Interface
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 alloc_val  out  1  a free preg is offered.
REQ-007 alloc_rdy  in  1  rename stage takes the offered preg.
REQ-008 alloc_preg  out  p_phys_addr_bits  preg offered, the current head entry.
REQ-009 complete_val  in  1  completion notification valid.
REQ-010 complete_wen  in  1  completing instruction writes a register.
REQ-011 complete_preg  in  p_phys_addr_bits  preg written by the completing instruction.
REQ-012 commit_val  in  1  commit notification valid.
REQ-013 commit_wen  in  1  committing instruction writes a register; already 0 for waddr==0.
REQ-014 commit_ppreg  in  p_phys_addr_bits  previous mapping of the destination register, to be freed.
REQ-015 query_preg[0:1]  in  2 x p_phys_addr_bits  source pregs to look up.
REQ-016 query_ready[0:1]  out  2 x 1  preg value is available.
REQ-017 free_count  out  p_phys_addr_bits+1  entries currently in the list.
REQ-018 overflow_err  out  1  sticky error flag.

Function
REQ-019 Storage SHALL be a circular buffer of p_depth entries, with head pointer, tail pointer and count; each pointer wraps from p_depth-1 to 0.
REQ-020 alloc_val SHALL be (count != 0), combinational from registered state only.
REQ-021 alloc_preg SHALL be buf[head]; its value is don't-care when alloc_val==0.
REQ-022 An allocation SHALL occur when alloc_val && alloc_rdy: head advances by 1 and count decrements by 1 at the next edge.
REQ-023 A free SHALL occur when commit_val && commit_wen: buf[tail] <= commit_ppreg, tail advances by 1 and count increments by 1.
REQ-024 A simultaneous allocation and free SHALL both take effect, leaving count unchanged.
REQ-025 There SHALL be no free-to-alloc bypass: with count==0, a preg freed in cycle N is first offered in cycle N+1.
REQ-026 Free with count==p_depth and no simultaneous allocation: the push SHALL be dropped, all state left unchanged, and overflow_err set to 1 until reset.
REQ-027 Ready table: one bit per preg; an allocation clears ready[alloc_preg] at the next edge.
REQ-028 Ready table: complete_val && complete_wen sets ready[complete_preg] at the next edge.
REQ-029 If an allocation and a completion target the same preg in the same cycle, the clear SHALL win.
REQ-030 query_ready[k] SHALL be ready[query_preg[k]] | (complete_val && complete_wen && complete_preg==query_preg[k]), giving a same-cycle completion bypass.
REQ-031 query_ready[k] SHALL be 1 for query_preg[k]==0 regardless of table state; preg 0 is never allocated.
REQ-032 free_count SHALL equal count, registered.

Reset
REQ-033 On rst: head=0, tail=0, count=p_depth, buf[i]=32+i for i in 0..p_depth-1, all ready bits=1, overflow_err=0.
REQ-034 rst SHALL take priority over a concurrent allocation, free or completion; mid-operation reset restores exactly the REQ-033 state at the next edge.
REQ-035 After rst deasserts, alloc_val=1 and alloc_preg=32 in the first cycle.

Verification (p_phys_addr_bits=6, p_depth=32)
REQ-036 Reset, then alloc_rdy=1 for 32 cycles -> alloc_preg sequence 32..63, then alloc_val=0 and free_count=0.
REQ-037 Empty list, commit_wen with ppreg=5 in cycle N -> alloc_val=0 in N, alloc_val=1 and alloc_preg=5 in N+1.
REQ-038 free_count=4, allocation and free of ppreg=9 in the same cycle -> free_count stays 4 and 9 is enqueued at the tail.
REQ-039 Full list, free of 7 with no allocation -> overflow_err=1 until rst, free_count=32, contents unchanged.
REQ-040 Allocate 40 (ready cleared); query 40 -> 0; complete 40 in cycle N -> query_ready=1 in N via bypass and from the table in N+1.
REQ-041 Reset asserted after 10 allocations and 3 frees -> next cycle free_count=32, alloc_preg=32, all query_ready=1.
